// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared constants for the UART program loader.
package inst_loader_pkg;
  localparam int          ADDRWIDTH = 10;
  localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;
  localparam logic [2:0]  LD_IDLE   = 3'd0;
  localparam logic [2:0]  LD_RECV   = 3'd1;
  localparam logic [2:0]  LD_WRITE  = 3'd2;
  localparam logic [2:0]  LD_DONE   = 3'd3;
  localparam logic [2:0]  LD_ERROR  = 3'd4;
  function automatic logic is_busy(input logic [2:0] s);
    return s == LD_RECV || s == LD_WRITE;
  endfunction
endpackage

// File: rtl/inst_loader_byte_to_word.sv
// byte_to_word: MSB-first byte shift register with a 2-bit byte counter.
module byte_to_word #(
  parameter int NB_DATA = 32,
  parameter int N_BITS  = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic               preload_i,
  input  logic [N_BITS-1:0]  data_i,
  output logic [NB_DATA-1:0] word_o,
  output logic               word_valid_o
);
  logic [NB_DATA-1:0] word_q, word_d;
  logic [1:0]         cnt_q, cnt_d;
  // preload starts a fresh word whose first byte is the one just taken
  always_comb begin
    word_d = clear_i ? '0 : (shift_i || preload_i) ? {word_q[NB_DATA-N_BITS-1:0], data_i} : word_q;
    cnt_d  = clear_i ? 2'd0 : preload_i ? 2'd1 : shift_i ? cnt_q + 2'd1 : cnt_q;
  end
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end
  assign word_o       = word_q;
  assign word_valid_o = shift_i && cnt_q == 2'd3;
endmodule

// File: rtl/inst_loader.sv
// inst_loader: assembles UART bytes into 32-bit words and writes them to
// instruction memory until HALT, flagging overflow if memory fills first.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int N_BITS  = 8,
  parameter int NB_ADDR = ADDRWIDTH
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               rx_done_i,
  input  logic [N_BITS-1:0]  rx_data_i,
  output logic               en_write_o,
  output logic [NB_ADDR-1:0] wr_addr_o,
  output logic [NB_DATA-1:0] inst_load_o,
  output logic               busy_o,
  output logic               load_done_o,
  output logic               error_o,
  output logic [NB_ADDR-2:0] word_count_o
);
  localparam logic [NB_ADDR-1:0] ADDR_LAST = {{(NB_ADDR-2){1'b1}}, 2'b00};
  logic [2:0]         state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [NB_ADDR-2:0] count_q, count_d;
  logic [NB_DATA-1:0] inst_q, inst_d, word;
  logic               en_write_q, busy_q, done_q, error_q;
  logic               clear, shift, preload, word_valid;
  assign shift = state_q == LD_RECV && rx_done_i && !abort_i;
  byte_to_word #(.NB_DATA(NB_DATA), .N_BITS(N_BITS)) u_b2w (
    .clock_i(clock_i), .reset_i(reset_i), .clear_i(clear), .shift_i(shift),
    .preload_i(preload), .data_i(rx_data_i), .word_o(word), .word_valid_o(word_valid)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    clear   = 1'b0;
    preload = 1'b0;
    if (abort_i) state_d = LD_IDLE;
    else case (state_q)
      LD_IDLE, LD_ERROR: if (start_i) begin
        state_d = LD_RECV;
        addr_d  = '0;
        count_d = '0;
        clear   = 1'b1;
      end
      LD_RECV: if (word_valid) begin
        state_d = LD_WRITE;
        count_d = count_q + (NB_ADDR-1)'(1);
      end
      LD_WRITE:
        if (word == HALT_INST) state_d = LD_DONE;
        else if (addr_q == ADDR_LAST) state_d = LD_ERROR;
        else begin
          state_d = LD_RECV;
          addr_d  = addr_q + NB_ADDR'(4);
          preload = rx_done_i;
        end
      default: state_d = LD_IDLE;
    endcase
    wr_addr_d = state_d == LD_WRITE ? addr_q : wr_addr_q;
    inst_d    = state_d == LD_WRITE ? {word[NB_DATA-N_BITS-1:0], rx_data_i} : inst_q;
  end
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= LD_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      wr_addr_q  <= '0;
      inst_q     <= '0;
      en_write_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_addr_q  <= wr_addr_d;
      inst_q     <= inst_d;
      en_write_q <= state_d == LD_WRITE;
      busy_q     <= is_busy(state_d);
      done_q     <= state_d == LD_DONE;
      error_q    <= state_d == LD_ERROR;
    end
  end
  assign en_write_o   = en_write_q;
  assign wr_addr_o    = wr_addr_q;
  assign inst_load_o  = inst_q;
  assign busy_o       = busy_q;
  assign load_done_o  = done_q;
  assign error_o      = error_q;
  assign word_count_o = count_q;
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: table vectors, directed corner sequences and random stimulus vs a queue-based model.
module tb_inst_loader;
  localparam int NB_ADDR = 4;
  logic clock_i = 1'b0, reset_i = 1'b0, start_i = 1'b0, abort_i = 1'b0, rx_done_i = 1'b0;
  logic [7:0]         rx_data_i = '0;
  logic               en_write_o, busy_o, load_done_o, error_o;
  logic [NB_ADDR-1:0] wr_addr_o;
  logic [31:0]        inst_load_o;
  logic [NB_ADDR-2:0] word_count_o;
  int vectors = 0, miscompares = 0;

  inst_loader #(.NB_DATA(32), .N_BITS(8), .NB_ADDR(NB_ADDR)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .rx_done_i(rx_done_i), .rx_data_i(rx_data_i), .en_write_o(en_write_o),
    .wr_addr_o(wr_addr_o), .inst_load_o(inst_load_o), .busy_o(busy_o),
    .load_done_o(load_done_o), .error_o(error_o), .word_count_o(word_count_o)
  );

  always #5 clock_i = ~clock_i;

  // reference model: phase 0 idle, 1 collecting bytes, 2 word just written, 3 done, 4 overflow
  int          m_phase, m_addr, m_cnt, m_wr_addr;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_word, m_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_addr = 0; m_cnt = 0; m_wr_addr = 0; m_inst = 0; m_word = 0;
    m_bytes.delete();
  endtask

  task automatic model_edge(input logic st, input logic ab, input logic rx, input logic [7:0] d);
    if (ab) m_phase = 0;
    else case (m_phase)
      0, 4: if (st) begin m_phase = 1; m_addr = 0; m_cnt = 0; m_bytes.delete(); end
      1: if (rx) begin
        m_bytes.push_back(d);
        if (m_bytes.size() == 4) begin
          m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_bytes.delete();
          m_wr_addr = m_addr; m_inst = m_word; m_cnt++; m_phase = 2;
        end
      end
      2: if (m_word == 32'hFFFF_FFFF) m_phase = 3;
         else if (m_addr == 2**NB_ADDR - 4) m_phase = 4;
         else begin m_addr += 4; m_phase = 1; if (rx) m_bytes.push_back(d); end
      3: m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_model();
    chk("model en_write", en_write_o, m_phase == 2);
    chk("model wr_addr", wr_addr_o, m_wr_addr);
    chk("model inst_load", inst_load_o, m_inst);
    chk("model busy", busy_o, m_phase == 1 || m_phase == 2);
    chk("model load_done", load_done_o, m_phase == 3);
    chk("model error", error_o, m_phase == 4);
    chk("model word_count", word_count_o, m_cnt);
  endtask

  // called at posedge+1; drives inputs, clocks once, checks at posedge+1
  task automatic step(input logic st, input logic ab, input logic rx, input logic [7:0] d);
    start_i = st; abort_i = ab; rx_done_i = rx; rx_data_i = d;
    @(posedge clock_i);
    if (!reset_i) model_reset(); else model_edge(st, ab, rx, d);
    #1;
    check_model();
  endtask

  task automatic idle(); step(0, 0, 0, 8'h00); endtask

  task automatic send_word(input logic [31:0] w, input int exp_addr, input string name);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w << (8 * i);
      step(0, 0, 1, t[31:24]);
      if (i < 3) idle();
    end
    chk({name, " we"}, en_write_o, 1'b1);
    chk({name, " addr"}, wr_addr_o, exp_addr);
    chk({name, " data"}, inst_load_o, w);
  endtask

  typedef struct {
    logic st, ab, rx; logic [7:0] d;
    logic we; logic [3:0] addr; logic [31:0] inst; logic busy, done; logic [2:0] cnt;
  } vec_t;
  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1,0,0,8'h00, 0,4'd0,32'h0,        1,0,3'd0};
    tbl[1]  = '{0,0,1,8'h11, 0,4'd0,32'h0,        1,0,3'd0};
    tbl[2]  = '{0,0,1,8'h22, 0,4'd0,32'h0,        1,0,3'd0};
    tbl[3]  = '{0,0,1,8'h33, 0,4'd0,32'h0,        1,0,3'd0};
    tbl[4]  = '{0,0,1,8'h44, 1,4'd0,32'h11223344, 1,0,3'd1};
    tbl[5]  = '{0,0,1,8'h01, 0,4'd0,32'h11223344, 1,0,3'd1};
    tbl[6]  = '{0,0,1,8'h02, 0,4'd0,32'h11223344, 1,0,3'd1};
    tbl[7]  = '{0,0,1,8'h03, 0,4'd0,32'h11223344, 1,0,3'd1};
    tbl[8]  = '{0,0,1,8'h04, 1,4'd4,32'h01020304, 1,0,3'd2};
    tbl[9]  = '{0,0,0,8'h00, 0,4'd4,32'h01020304, 1,0,3'd2};
    tbl[10] = '{0,0,1,8'hFF, 0,4'd4,32'h01020304, 1,0,3'd2};
    tbl[11] = '{0,0,1,8'hFF, 0,4'd4,32'h01020304, 1,0,3'd2};
    tbl[12] = '{0,0,1,8'hFF, 0,4'd4,32'h01020304, 1,0,3'd2};
    tbl[13] = '{0,0,1,8'hFF, 1,4'd8,32'hFFFFFFFF, 1,0,3'd3};
    tbl[14] = '{0,0,0,8'h00, 0,4'd8,32'hFFFFFFFF, 0,1,3'd3};
    tbl[15] = '{0,0,0,8'h00, 0,4'd8,32'hFFFFFFFF, 0,0,3'd3};

    model_reset();
    #2;
    chk("reset en_write", en_write_o, 0);
    chk("reset busy", busy_o, 0);
    check_model();
    #10 reset_i = 1'b1;
    @(posedge clock_i); #1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].st, tbl[i].ab, tbl[i].rx, tbl[i].d);
      chk($sformatf("tbl%0d we", i), en_write_o, tbl[i].we);
      chk($sformatf("tbl%0d addr", i), wr_addr_o, tbl[i].addr);
      chk($sformatf("tbl%0d inst", i), inst_load_o, tbl[i].inst);
      chk($sformatf("tbl%0d busy", i), busy_o, tbl[i].busy);
      chk($sformatf("tbl%0d done", i), load_done_o, tbl[i].done);
      chk($sformatf("tbl%0d cnt", i), word_count_o, tbl[i].cnt);
    end

    // normal load with gaps between bytes
    step(1, 0, 0, 8'h00);
    send_word(32'h20010005, 0, "load w0"); idle();
    send_word(32'h00000000, 4, "load w1"); idle();
    send_word(32'hFFFFFFFF, 8, "load halt");
    idle(); chk("load done pulse", load_done_o, 1);
    idle(); chk("load done once", load_done_o, 0);
    chk("load count", word_count_o, 3);

    // overflow on a 16-byte memory
    step(1, 0, 0, 8'h00);
    for (int w = 0; w < 4; w++) begin
      send_word(32'h0A0B0C00 + w, 4 * w, "ovf");
      idle();
    end
    chk("ovf error", error_o, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 8'h55);
      chk("ovf no write", en_write_o, 0);
    end
    chk("ovf error held", error_o, 1);
    step(1, 0, 0, 8'h00);
    chk("ovf cleared", error_o, 0);
    send_word(32'hCAFE0001, 0, "ovf restart"); idle();

    // abort mid-word, then a fresh load starts at 0
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h99); step(0, 0, 1, 8'h88);
    step(0, 1, 1, 8'h77);
    chk("abort busy", busy_o, 0);
    chk("abort no write", en_write_o, 0);
    step(0, 0, 1, 8'h66); step(0, 0, 1, 8'h66); step(0, 0, 1, 8'h66);
    chk("abort idle ignores bytes", en_write_o, 0);
    step(1, 0, 0, 8'h00);
    send_word(32'h12345678, 0, "after abort"); idle();

    // asynchronous reset after six bytes
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'h30 + 8'(i));
    #2 reset_i = 1'b0;
    #1;
    model_reset();
    chk("rst busy", busy_o, 0);
    chk("rst count", word_count_o, 0);
    check_model();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 8'h40);
      chk("rst no write", en_write_o, 0);
    end
    reset_i = 1'b1;

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic st, ab, rx; logic [7:0] d;
      st = ($urandom % 30) == 0;
      ab = ($urandom % 80) == 0;
      rx = ($urandom % 3) != 0;
      d  = ($urandom % 5 == 0) ? 8'hFF : 8'($urandom);
      step(st, ab, rx, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
